// File: rtl/ns3_acq_pkg.sv
// Shared state and mode codes for the NS3 acquisition sequencer.
package ns3_acq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRETRIG  = 3'd1,
        ARMED    = 3'd2,
        POSTTRIG = 3'd3,
        DONE     = 3'd4
    } acq_state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_SINGLE = 2'b10,
        MODE_FREE   = 2'b11
    } acq_mode_t;

endpackage

// File: rtl/acq_strobe_counter.sv
// Strobe-gated saturating counter; hit flags the count one short of term,
// so the strobe that lands on term is the one that sees hit=1.
module acq_strobe_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         hit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + W'(1);
    end

    assign hit = (cnt == term - W'(1));

endmodule

// File: rtl/acq_sequencer.sv
// Capture sequencer: pre-trigger fill, arm, optional auto-timeout trigger,
// post-trigger fill, then MCU read handshake. All outputs are registered.
module acq_sequencer
    import ns3_acq_pkg::*;
#(
    parameter int PRE_W = 18,
    parameter int TO_W  = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLK_EN,
    input  logic [1:0]       Mode,
    input  logic             Start_Cmd,
    input  logic             Stop_Cmd,
    input  logic [PRE_W-1:0] Pretrig_Len,
    input  logic [TO_W-1:0]  Auto_Timeout,
    input  logic             Write_Ready,
    input  logic             Trig_Seen,
    input  logic             Read_Done,
    output logic             Start_Write,
    output logic             Enable_Trig,
    output logic             Sync_ON,
    output logic             Data_Ready,
    output logic             Auto_Fired,
    output logic [2:0]       Acq_State
);

    acq_state_t       state, state_nx;
    acq_mode_t        mode_q, mode_nx;
    logic [PRE_W-1:0] len_q;
    logic [TO_W-1:0]  tmo_q;
    logic             enter_pre, enter_arm, auto_fire;
    logic             pre_hit, to_hit;
    logic             sw_nx, et_nx, sync_nx, dr_nx, af_nx;

    assign enter_pre = (state_nx == PRETRIG) && (state != PRETRIG);
    assign enter_arm = (state_nx == ARMED) && (state != ARMED);

    acq_strobe_counter #(.W(PRE_W)) u_pre_cnt (
        .clk  (CLK),
        .rst  (RESET),
        .clr  (enter_pre),
        .en   (CLK_EN && state == PRETRIG),
        .term (len_q),
        .hit  (pre_hit)
    );

    acq_strobe_counter #(.W(TO_W)) u_to_cnt (
        .clk  (CLK),
        .rst  (RESET),
        .clr  (enter_pre),
        .en   (CLK_EN && state == ARMED),
        .term (tmo_q),
        .hit  (to_hit)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            mode_q      <= MODE_NORMAL;
            len_q       <= '0;
            tmo_q       <= '0;
            Start_Write <= 1'b0;
            Enable_Trig <= 1'b0;
            Sync_ON     <= 1'b0;
            Data_Ready  <= 1'b0;
            Auto_Fired  <= 1'b0;
        end else begin
            state       <= state_nx;
            mode_q      <= mode_nx;
            if (enter_pre) len_q <= Pretrig_Len;
            if (enter_arm) tmo_q <= Auto_Timeout;
            Start_Write <= sw_nx;
            Enable_Trig <= et_nx;
            Sync_ON     <= sync_nx;
            Data_Ready  <= dr_nx;
            Auto_Fired  <= af_nx;
        end
    end

    // A real trigger in the same cycle as the timeout takes precedence.
    always_comb begin
        state_nx  = state;
        auto_fire = 1'b0;
        case (state)
            IDLE:     if (Start_Cmd) state_nx = PRETRIG;
            PRETRIG:  if (len_q == '0 || (CLK_EN && pre_hit)) state_nx = ARMED;
            ARMED: begin
                if (Trig_Seen)
                    state_nx = POSTTRIG;
                else if (mode_q == MODE_AUTO && tmo_q != '0 && CLK_EN && to_hit) begin
                    state_nx  = POSTTRIG;
                    auto_fire = 1'b1;
                end
            end
            POSTTRIG: if (Write_Ready) state_nx = DONE;
            DONE:     if (Read_Done) state_nx = (mode_q == MODE_SINGLE) ? IDLE : PRETRIG;
            default:  state_nx = IDLE;
        endcase
        if (Stop_Cmd) begin
            state_nx  = IDLE;
            auto_fire = 1'b0;
        end
    end

    // Next register values for outputs, derived from the upcoming state.
    always_comb begin
        mode_nx = enter_pre ? acq_mode_t'(Mode) : mode_q;
        if (Stop_Cmd || enter_pre)
            af_nx = 1'b0;
        else
            af_nx = auto_fire | Auto_Fired;
        sw_nx   = state_nx inside {PRETRIG, ARMED, POSTTRIG};
        et_nx   = state_nx inside {ARMED, POSTTRIG};
        dr_nx   = (state_nx == DONE);
        sync_nx = (state_nx != IDLE) && (mode_nx != MODE_FREE) && !af_nx;
    end

    assign Acq_State = state;

endmodule

// File: tb/tb_acq_sequencer.sv
// Randomized bench for acq_sequencer against a transaction-level capture model.
module tb_acq_sequencer;

    localparam int PRE_W = 18;
    localparam int TO_W  = 16;

    logic             CLK = 1'b0, RESET = 1'b0, CLK_EN = 1'b0;
    logic [1:0]       Mode = 2'b00;
    logic             Start_Cmd = 1'b0, Stop_Cmd = 1'b0;
    logic [PRE_W-1:0] Pretrig_Len = '0;
    logic [TO_W-1:0]  Auto_Timeout = '0;
    logic             Write_Ready = 1'b0, Trig_Seen = 1'b0, Read_Done = 1'b0;
    logic             Start_Write, Enable_Trig, Sync_ON, Data_Ready, Auto_Fired;
    logic [2:0]       Acq_State;

    int vectors = 0;
    int miscompares = 0;

    acq_sequencer #(.PRE_W(PRE_W), .TO_W(TO_W)) dut (
        .CLK(CLK), .RESET(RESET), .CLK_EN(CLK_EN), .Mode(Mode),
        .Start_Cmd(Start_Cmd), .Stop_Cmd(Stop_Cmd), .Pretrig_Len(Pretrig_Len),
        .Auto_Timeout(Auto_Timeout), .Write_Ready(Write_Ready), .Trig_Seen(Trig_Seen),
        .Read_Done(Read_Done), .Start_Write(Start_Write), .Enable_Trig(Enable_Trig),
        .Sync_ON(Sync_ON), .Data_Ready(Data_Ready), .Auto_Fired(Auto_Fired),
        .Acq_State(Acq_State)
    );

    always #5 CLK = ~CLK;

    // Capture model: phase 0..4, strobes written/waited, captured settings.
    typedef struct {
        int st; int pre; int to; int mode; int len; int tmo; bit af;
    } mdl_t;
    mdl_t m = '{default: 0};

    function automatic mdl_t begin_capture(mdl_t c);
        mdl_t n = c;
        n.st = 1; n.pre = 0; n.to = 0; n.af = 1'b0;
        n.mode = int'(Mode); n.len = int'(Pretrig_Len);
        return n;
    endfunction

    function automatic mdl_t next_m(mdl_t c);
        mdl_t n = c;
        case (c.st)
            0: if (Start_Cmd) n = begin_capture(c);
            1: begin
                if (CLK_EN) n.pre = c.pre + 1;
                if (c.len == 0 || (CLK_EN && n.pre == c.len)) begin
                    n.st = 2; n.tmo = int'(Auto_Timeout);
                end
            end
            2: begin
                if (Trig_Seen) n.st = 3;
                else if (c.mode == 1 && c.tmo != 0 && CLK_EN) begin
                    n.to = c.to + 1;
                    if (n.to == c.tmo) begin n.st = 3; n.af = 1'b1; end
                end
            end
            3: if (Write_Ready) n.st = 4;
            4: if (Read_Done) begin
                if (c.mode == 2) n.st = 0;
                else n = begin_capture(c);
            end
            default: n.st = 0;
        endcase
        if (Stop_Cmd) begin n.st = 0; n.af = 1'b0; end
        return n;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) m <= '{default: 0};
        else       m <= next_m(m);
    end

    function automatic logic [7:0] dut_vec();
        return {Acq_State, Start_Write, Enable_Trig, Sync_ON, Data_Ready, Auto_Fired};
    endfunction

    function automatic logic [7:0] mdl_vec();
        logic sw, et, so, dr;
        sw = (m.st >= 1 && m.st <= 3);
        et = (m.st == 2 || m.st == 3);
        so = (m.st != 0) && (m.mode != 3) && !m.af;
        dr = (m.st == 4);
        return {3'(m.st), sw, et, so, dr, m.af};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_pulses();
        Start_Cmd = 0; Stop_Cmd = 0; Trig_Seen = 0; Write_Ready = 0; Read_Done = 0;
    endtask

    task automatic test_reset();
        #2 RESET = 1'b1;
        #1;
        vectors++;
        if (dut_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: got %b want 00000000", dut_vec());
        end
        tick(); tick();
        RESET = 1'b0;
        tick();
        vectors++;
        if (dut_vec() !== 8'h00 || mdl_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_release: got %b want 00000000", dut_vec());
        end
    endtask

    task automatic test_normal();
        int strobes = 0;
        bit last_en = 0, seen_et = 0;
        Mode = 2'b00; Pretrig_Len = 4; Auto_Timeout = TO_W'($urandom_range(1, 5));
        Start_Cmd = 1; CLK_EN = 0;
        for (int i = 0; i < 70; i++) begin
            if (m.st == 1 && CLK_EN) strobes++;
            last_en = CLK_EN;
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL normal cyc %0d: got %b want %b", i, dut_vec(), mdl_vec());
            end
            if (!seen_et && Enable_Trig === 1'b1) begin
                seen_et = 1;
                vectors++;
                if (strobes != 4 || !last_en) begin
                    miscompares++;
                    $display("FAIL normal_arm_timing: strobes %0d last_en %0d want 4 1", strobes, last_en);
                end
            end
            clear_pulses();
            CLK_EN      = (i % 2 == 0);
            Trig_Seen   = (m.st == 2) && ($urandom_range(0, 2) == 0);
            Write_Ready = (m.st == 3) && ($urandom_range(0, 1) == 0);
            Read_Done   = (m.st == 4) && ($urandom_range(0, 1) == 0);
        end
        Stop_Cmd = 1; tick(); clear_pulses();
    endtask

    task automatic test_auto();
        int armed = 0;
        int i = 0;
        Mode = 2'b01; Auto_Timeout = 10; Pretrig_Len = PRE_W'($urandom_range(1, 4));
        Start_Cmd = 1; CLK_EN = 1;
        while (m.st != 3 && i < 200) begin
            if (m.st == 2 && CLK_EN) armed++;
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL auto cyc %0d: got %b want %b", i, dut_vec(), mdl_vec());
            end
            clear_pulses();
            CLK_EN = ($urandom_range(0, 1) == 0);
            i++;
        end
        vectors++;
        if (Acq_State !== 3'd3 || Sync_ON !== 1'b0 || Auto_Fired !== 1'b1 || armed != 10) begin
            miscompares++;
            $display("FAIL auto_fire: state %0d sync %b af %b strobes %0d want 3 0 1 10",
                     Acq_State, Sync_ON, Auto_Fired, armed);
        end
        Stop_Cmd = 1; tick(); clear_pulses();
    endtask

    task automatic test_single();
        Mode = 2'b10; Pretrig_Len = PRE_W'($urandom_range(1, 3)); Auto_Timeout = 3;
        Start_Cmd = 1; CLK_EN = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL single cyc %0d: got %b want %b", i, dut_vec(), mdl_vec());
            end
            clear_pulses();
            Trig_Seen   = ($urandom_range(0, 1) == 0);
            Write_Ready = ($urandom_range(0, 1) == 0);
            Read_Done   = (m.st == 4) || ($urandom_range(0, 3) == 0);
        end
        vectors++;
        if (Acq_State !== 3'd0 || Data_Ready !== 1'b0 || Start_Write !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: state %0d dr %b sw %b want 0 0 0", Acq_State, Data_Ready, Start_Write);
        end
        clear_pulses();
    endtask

    task automatic test_zero_free();
        Mode = 2'b11; Pretrig_Len = 0; CLK_EN = 0; Start_Cmd = 1;
        tick(); clear_pulses();
        vectors++;
        if (Acq_State !== 3'd1 || Sync_ON !== 1'b0 || Start_Write !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_pre_entry: state %0d sync %b sw %b want 1 0 1", Acq_State, Sync_ON, Start_Write);
        end
        tick();
        vectors++;
        if (Acq_State !== 3'd2 || Enable_Trig !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_pre_arm: state %0d et %b want 2 1", Acq_State, Enable_Trig);
        end
        for (int i = 0; i < 30; i++) begin
            CLK_EN      = ($urandom_range(0, 1) == 0);
            Trig_Seen   = ($urandom_range(0, 2) == 0);
            Write_Ready = ($urandom_range(0, 2) == 0);
            Read_Done   = ($urandom_range(0, 2) == 0);
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec() || Sync_ON !== 1'b0) begin
                miscompares++;
                $display("FAIL free cyc %0d: got %b want %b", i, dut_vec(), mdl_vec());
            end
            clear_pulses();
        end
        Stop_Cmd = 1; tick(); clear_pulses();
    endtask

    task automatic test_stop();
        int i = 0;
        Mode = 2'b00; Pretrig_Len = 1; CLK_EN = 1;
        Start_Cmd = 1; Stop_Cmd = 1;
        tick(); clear_pulses();
        vectors++;
        if (dut_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL stop_vs_start: got %b want 00000000", dut_vec());
        end
        Start_Cmd = 1;
        while (m.st != 4 && i < 50) begin
            tick(); clear_pulses();
            Trig_Seen = 1; Write_Ready = 1;
            i++;
        end
        clear_pulses();
        vectors++;
        if (Data_Ready !== 1'b1 || Acq_State !== 3'd4) begin
            miscompares++;
            $display("FAIL stop_reach_done: state %0d dr %b want 4 1", Acq_State, Data_Ready);
        end
        Stop_Cmd = 1; Read_Done = 1;
        tick(); clear_pulses();
        vectors++;
        if (dut_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL stop_vs_read: got %b want 00000000", dut_vec());
        end
    endtask

    task automatic test_reset_mid();
        int i = 0;
        Mode = 2'($urandom_range(0, 2)); Pretrig_Len = 2; CLK_EN = 1; Start_Cmd = 1;
        while (m.st != 3 && i < 50) begin
            tick(); clear_pulses();
            Trig_Seen = (m.st == 2);
            i++;
        end
        clear_pulses();
        vectors++;
        if (Acq_State !== 3'd3) begin
            miscompares++;
            $display("FAIL reset_mid_reach: state %0d want 3", Acq_State);
        end
        #2 RESET = 1'b1;
        #1;
        vectors++;
        if (dut_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %b want 00000000", dut_vec());
        end
        tick();
        RESET = 1'b0; Mode = 2'b00; Pretrig_Len = 3; Start_Cmd = 1;
        for (int k = 0; k < 12; k++) begin
            tick(); clear_pulses();
            vectors++;
            if (dut_vec() !== mdl_vec() || (k == 0 && Acq_State !== 3'd1)) begin
                miscompares++;
                $display("FAIL reset_mid_restart cyc %0d: got %b want %b", k, dut_vec(), mdl_vec());
            end
        end
        Stop_Cmd = 1; tick(); clear_pulses();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Mode         = 2'($urandom_range(0, 3));
            Pretrig_Len  = PRE_W'($urandom_range(0, 5));
            Auto_Timeout = TO_W'($urandom_range(0, 5));
            CLK_EN       = ($urandom_range(0, 2) != 0);
            Start_Cmd    = ($urandom_range(0, 3) == 0);
            Stop_Cmd     = ($urandom_range(0, 29) == 0);
            Trig_Seen    = ($urandom_range(0, 3) == 0);
            Write_Ready  = ($urandom_range(0, 2) == 0);
            Read_Done    = ($urandom_range(0, 2) == 0);
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b want %b", i, dut_vec(), mdl_vec());
            end
        end
        clear_pulses();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_auto();
        test_single();
        test_zero_free();
        test_stop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
